// File: rtl/fxp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fxp_pkg
//  Description : Shared types for the fixed-point op sequencer: opcode and
//                FSM state encodings plus the default-width request layout.
//  Revision    : 1.0 - initial release
// ============================================================================
package fxp_pkg;

    // Arithmetic unit opcodes; 2'b11 is reserved and never issued.
    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_MUL  = 2'b01,
        OP_DIV  = 2'b10,
        OP_RSVD = 2'b11
    } fxp_opcode_t;

    // Sequencer control states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_WAIT  = 2'b10,
        ST_HOLD  = 2'b11
    } fxp_seq_state_t;

    localparam int c_fxp_width = 32;

    // Request layout at the default operand width; the FIFO stores the same
    // field order flattened to {opcode, a, b}.
    typedef struct packed {
        fxp_opcode_t              opcode;
        logic [c_fxp_width-1:0]   a;
        logic [c_fxp_width-1:0]   b;
    } fxp_req_t;

endpackage
`default_nettype wire

// File: rtl/fxp_req_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : fxp_req_fifo
//  Description : Synchronous request FIFO, DEPTH entries (power of two),
//                show-ahead read data, occupancy count 0..DEPTH.
//  Revision    : 1.0 - initial release
// ============================================================================
module fxp_req_fifo #(
    parameter int WIDTH = 66,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_push_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_pop_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);
    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = $clog2(DEPTH+1);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic               w_push;
    logic               w_pop;

    assign o_full     = (r_count == c_cnt_w'(DEPTH));
    assign o_empty    = (r_count == '0);
    assign o_count    = r_count;
    assign o_pop_data = r_mem[r_rd_ptr];
    assign w_push     = i_push & ~o_full;
    assign w_pop      = i_pop & ~o_empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (w_pop && !w_push) r_count <= r_count - 1'b1;
        end
    end

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_push_data;
    end

endmodule
`default_nettype wire

// File: rtl/fxp_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : fxp_op_sequencer
//  Description : Buffers add/mul/div requests, issues them one at a time to
//                the fixed-point arithmetic unit and returns results in order.
//                Optional div watchdog enabled by macro FXP_SEQ_TIMEOUT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module fxp_op_sequencer
    import fxp_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 4,
    parameter int ALU_LAT = 2,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [1:0]       in_opcode,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [1:0]       alu_opcode,
    output logic             alu_start,
    input  logic [WIDTH-1:0] alu_c,
    input  logic             alu_done,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [1:0]       out_opcode,
    output logic             out_err
);
    localparam int c_req_w      = 2 + 2*WIDTH;
    localparam int c_fifo_cnt_w = $clog2(DEPTH+1);
    // One down-counter serves both the add/mul latency and the div watchdog.
    localparam int c_cnt_max    = (ALU_LAT > TIMEOUT) ? ALU_LAT : TIMEOUT;
    localparam int c_cnt_w      = $clog2(c_cnt_max + 1);
    localparam logic [c_cnt_w-1:0] c_lat_load = c_cnt_w'(ALU_LAT - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
`ifdef FXP_SEQ_TIMEOUT_EN
    localparam logic [c_cnt_w-1:0] c_tmo_load = c_cnt_w'(TIMEOUT - 1);
`endif

    logic                    w_push;
    logic                    w_pop;
    logic [c_req_w-1:0]      w_pop_data;
    logic                    w_full;
    logic                    w_empty;
    logic [c_fifo_cnt_w-1:0] w_count;
    fxp_opcode_t             w_req_op;
    logic [WIDTH-1:0]        w_req_a;
    logic [WIDTH-1:0]        w_req_b;

    fxp_seq_state_t   r_state,      w_state_nxt;
    logic [c_cnt_w-1:0] r_cnt,      w_cnt_nxt;
    logic [WIDTH-1:0] r_alu_a,      w_alu_a_nxt;
    logic [WIDTH-1:0] r_alu_b,      w_alu_b_nxt;
    fxp_opcode_t      r_alu_op,     w_alu_op_nxt;
    logic [WIDTH-1:0] r_out_result, w_out_result_nxt;
    fxp_opcode_t      r_out_op,     w_out_op_nxt;
    logic             r_out_err,    w_out_err_nxt;

    assign in_ready = (w_count != c_fifo_cnt_w'(DEPTH));
    assign w_push   = in_valid & ~w_full;
    assign w_req_op = fxp_opcode_t'(w_pop_data[c_req_w-1 -: 2]);
    assign w_req_a  = w_pop_data[2*WIDTH-1 -: WIDTH];
    assign w_req_b  = w_pop_data[WIDTH-1:0];

    fxp_req_fifo #(
        .WIDTH (c_req_w),
        .DEPTH (DEPTH)
    ) u_req_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_data ({in_opcode, in_a, in_b}),
        .i_pop       (w_pop),
        .o_pop_data  (w_pop_data),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_count     (w_count)
    );

    // Start and valid decode straight from state so reset drops them at once.
    assign alu_start  = (r_state == ST_ISSUE);
    assign out_valid  = (r_state == ST_HOLD);
    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign alu_opcode = r_alu_op;
    assign out_result = r_out_result;
    assign out_opcode = r_out_op;
    assign out_err    = r_out_err;

    // State, latency counter and output holding registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_op     <= OP_ADD;
            r_out_result <= '0;
            r_out_op     <= OP_ADD;
            r_out_err    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_alu_a      <= w_alu_a_nxt;
            r_alu_b      <= w_alu_b_nxt;
            r_alu_op     <= w_alu_op_nxt;
            r_out_result <= w_out_result_nxt;
            r_out_op     <= w_out_op_nxt;
            r_out_err    <= w_out_err_nxt;
        end
    end

    // Next-state and register-load decisions for the issue/wait/hold cycle.
    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_alu_a_nxt      = r_alu_a;
        w_alu_b_nxt      = r_alu_b;
        w_alu_op_nxt     = r_alu_op;
        w_out_result_nxt = r_out_result;
        w_out_op_nxt     = r_out_op;
        w_out_err_nxt    = r_out_err;
        w_pop            = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_out_op_nxt = w_req_op;
                    if (w_req_op == OP_RSVD) begin
                        // Reserved opcode is answered locally, never issued.
                        w_out_result_nxt = '0;
                        w_out_err_nxt    = 1'b1;
                        w_state_nxt      = ST_HOLD;
                    end else begin
                        w_alu_a_nxt  = w_req_a;
                        w_alu_b_nxt  = w_req_b;
                        w_alu_op_nxt = w_req_op;
                        w_state_nxt  = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                w_cnt_nxt = c_lat_load;
`ifdef FXP_SEQ_TIMEOUT_EN
                if (r_alu_op == OP_DIV) w_cnt_nxt = c_tmo_load;
`endif
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (r_alu_op == OP_DIV) begin
                    if (alu_done) begin
                        w_out_result_nxt = alu_c;
                        w_out_err_nxt    = 1'b0;
                        w_state_nxt      = ST_HOLD;
                    end
`ifdef FXP_SEQ_TIMEOUT_EN
                    else if (r_cnt == '0) begin
                        w_out_result_nxt = '0;
                        w_out_err_nxt    = 1'b1;
                        w_state_nxt      = ST_HOLD;
                    end else begin
                        w_cnt_nxt = r_cnt - 1'b1;
                    end
`endif
                end else if (r_cnt <= c_cnt_one) begin
                    // Final decrement coincides with sampling the result, so
                    // the result is valid ALU_LAT cycles after the start pulse.
                    w_out_result_nxt = alu_c;
                    w_out_err_nxt    = 1'b0;
                    w_state_nxt      = ST_HOLD;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            ST_HOLD: begin
                if (out_ready) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_fxp_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fxp_op_sequencer
//  Description : Directed self-checking bench for fxp_op_sequencer with a
//                small behavioural arithmetic unit. Watchdog case is compiled
//                only with FXP_SEQ_TIMEOUT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fxp_op_sequencer;
    localparam int WIDTH   = 32;
    localparam int DEPTH   = 4;
    localparam int ALU_LAT = 2;
    localparam int TIMEOUT = 64;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [1:0]       in_opcode;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [1:0]       alu_opcode;
    logic             alu_start;
    logic [WIDTH-1:0] alu_c;
    logic             alu_done;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic [1:0]       out_opcode;
    logic             out_err;

    int n_cmp = 0;
    int n_bad = 0;

    logic [WIDTH-1:0] model_c = '0;
    logic [WIDTH-1:0] div_val;
    logic             div_drive;

    fxp_op_sequencer #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .ALU_LAT (ALU_LAT),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_opcode  (in_opcode),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_opcode (alu_opcode),
        .alu_start  (alu_start),
        .alu_c      (alu_c),
        .alu_done   (alu_done),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_opcode (out_opcode),
        .out_err    (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural add/mul unit: result appears the cycle after the start pulse.
    assign alu_c = div_drive ? div_val : model_c;
    always @(posedge clk) begin
        if (alu_start) begin
            case (alu_opcode)
                2'b00:   model_c <= alu_a + alu_b;
                2'b01:   model_c <= alu_a * alu_b;
                default: model_c <= 32'hDEAD_BEEF;
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1 rst = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
        n_cmp++; if (alu_start !== 1'b0) begin n_bad++; $display("FAIL rst_alu_start: got %b want 0", alu_start); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        n_cmp++; if ({alu_a, alu_b, alu_opcode} !== '0) begin n_bad++; $display("FAIL rst_alu_regs: got %h %h %b want 0", alu_a, alu_b, alu_opcode); end
        n_cmp++; if ({out_result, out_opcode, out_err} !== '0) begin n_bad++; $display("FAIL rst_out_regs: got %h %b %b want 0", out_result, out_opcode, out_err); end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_add();
        in_valid = 1'b1; in_a = 32'h0080_0000; in_b = 32'h0080_0000; in_opcode = 2'b00;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL add_accept: got %b want 1", in_ready); end
        tick(); in_valid = 1'b0;                       // cycle N+1
        n_cmp++; if (alu_start !== 1'b0) begin n_bad++; $display("FAIL add_start_early: got %b want 0", alu_start); end
        tick();                                        // cycle N+2
        n_cmp++; if (alu_start !== 1'b1) begin n_bad++; $display("FAIL add_start: got %b want 1", alu_start); end
        n_cmp++; if ({alu_a, alu_b, alu_opcode} !== {32'h0080_0000, 32'h0080_0000, 2'b00}) begin
            n_bad++; $display("FAIL add_alu_operands: got %h %h %b want 00800000 00800000 00", alu_a, alu_b, alu_opcode); end
        tick();                                        // cycle N+3
        n_cmp++; if ({alu_start, out_valid} !== 2'b00) begin n_bad++; $display("FAIL add_wait: got start=%b valid=%b want 0 0", alu_start, out_valid); end
        tick();                                        // cycle N+4
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL add_valid_n4: got %b want 1", out_valid); end
        n_cmp++; if (out_result !== 32'h0100_0000) begin n_bad++; $display("FAIL add_result: got %h want 01000000", out_result); end
        n_cmp++; if ({out_err, out_opcode} !== 3'b000) begin n_bad++; $display("FAIL add_err_op: got err=%b op=%b want 0 00", out_err, out_opcode); end
        tick();                                        // still held, out_ready low
        n_cmp++; if ({out_valid, out_result} !== {1'b1, 32'h0100_0000}) begin n_bad++; $display("FAIL add_hold: got %b %h want 1 01000000", out_valid, out_result); end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL add_release: got %b want 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ea [5] = '{32'd2, 32'd4, 32'd7, 32'h10, 32'hFFFF};
        logic [31:0] eb [5] = '{32'd3, 32'd5, 32'd8, 32'h10, 32'd2};
        logic [31:0] er [5] = '{32'd6, 32'd20, 32'd56, 32'h100, 32'h1FFFE};
        int w;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_a = ea[i]; in_b = eb[i]; in_opcode = 2'b01;
            n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready_%0d: got %b want 1", i, in_ready); end
            tick();
        end
        in_a = 32'hBAD; in_b = 32'hBAD; in_opcode = 2'b00;   // must be ignored while full
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_full: got %b want 0", in_ready); end
        tick(); in_valid = 1'b0;
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_full_hold: got %b want 0", in_ready); end
        n_cmp++; if ({out_valid, out_opcode, out_result} !== {1'b1, 2'b01, er[0]}) begin
            n_bad++; $display("FAIL b2b_res_0: got v=%b op=%b %h want 1 01 %h", out_valid, out_opcode, out_result, er[0]); end
        out_ready = 1'b1; tick(); out_ready = 1'b0;          // IDLE, popping
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_pop_cycle: got %b want 0", in_ready); end
        tick();
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_slot_freed: got %b want 1", in_ready); end
        for (int i = 1; i < 5; i++) begin
            w = 0;
            while (out_valid !== 1'b1 && w < 20) begin tick(); w++; end
            n_cmp++; if ({out_valid, out_opcode, out_result} !== {1'b1, 2'b01, er[i]}) begin
                n_bad++; $display("FAIL b2b_res_%0d: got v=%b op=%b %h want 1 01 %h", i, out_valid, out_opcode, out_result, er[i]); end
            out_ready = 1'b1; tick(); out_ready = 1'b0;
        end
        repeat (8) tick();
        n_cmp++; if ({out_valid, in_ready} !== 2'b01) begin n_bad++; $display("FAIL b2b_no_extra: got v=%b rdy=%b want 0 1", out_valid, in_ready); end
    endtask

    task automatic test_div();
        int w;
        int early;
        in_valid = 1'b1; in_a = 32'd100; in_b = 32'd7; in_opcode = 2'b10;
        tick(); in_valid = 1'b0;
        w = 0;
        while (alu_start !== 1'b1 && w < 10) begin tick(); w++; end
        n_cmp++; if (alu_start !== 1'b1) begin n_bad++; $display("FAIL div_start: got %b want 1", alu_start); end
        early = 0;
        repeat (20) begin tick(); if (out_valid === 1'b1) early++; end
        n_cmp++; if (early != 0) begin n_bad++; $display("FAIL div_valid_before_done: got %0d want 0", early); end
        div_val = 32'h000E_4925; div_drive = 1'b1; alu_done = 1'b1;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL div_valid_same_cycle: got %b want 0", out_valid); end
        tick(); alu_done = 1'b0;
        n_cmp++; if ({out_valid, out_opcode, out_err, out_result} !== {1'b1, 2'b10, 1'b0, 32'h000E_4925}) begin
            n_bad++; $display("FAIL div_result: got v=%b op=%b err=%b %h want 1 10 0 000e4925", out_valid, out_opcode, out_err, out_result); end
        div_drive = 1'b0;
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        alu_done = 1'b1; tick(); alu_done = 1'b0;
        repeat (2) tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL div_done_idle_ignored: got %b want 0", out_valid); end
    endtask

    task automatic test_reserved();
        int w;
        int starts;
        in_valid = 1'b1; in_a = 32'h5; in_b = 32'h9; in_opcode = 2'b11;
        tick(); in_valid = 1'b0;
        w = 0; starts = 0;
        while (out_valid !== 1'b1 && w < 10) begin
            if (alu_start === 1'b1) starts++;
            tick(); w++;
        end
        n_cmp++; if (w != 1) begin n_bad++; $display("FAIL rsvd_latency: got %0d want 1", w); end
        n_cmp++; if ({out_valid, out_opcode, out_err, out_result} !== {1'b1, 2'b11, 1'b1, 32'h0}) begin
            n_bad++; $display("FAIL rsvd_result: got v=%b op=%b err=%b %h want 1 11 1 0", out_valid, out_opcode, out_err, out_result); end
        n_cmp++; if (alu_a !== 32'd100) begin n_bad++; $display("FAIL rsvd_alu_a_held: got %h want 00000064", alu_a); end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        repeat (4) begin if (alu_start === 1'b1) starts++; tick(); end
        n_cmp++; if (starts != 0) begin n_bad++; $display("FAIL rsvd_no_start: got %0d want 0", starts); end
    endtask

    task automatic test_reset_mid();
        int seen;
        in_valid = 1'b1; in_a = 32'h40; in_b = 32'h2; in_opcode = 2'b10;
        tick();
        in_a = 32'h1; in_b = 32'h2; in_opcode = 2'b00;
        tick();
        in_a = 32'h3; in_b = 32'h4; in_opcode = 2'b00;
        tick(); in_valid = 1'b0;
        tick();                                         // div in WAIT, 2 queued
        n_cmp++; if ({alu_a, alu_opcode} !== {32'h40, 2'b10}) begin n_bad++; $display("FAIL rmid_pre: got %h %b want 00000040 10", alu_a, alu_opcode); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if ({in_ready, alu_start, out_valid} !== 3'b100) begin n_bad++; $display("FAIL rmid_ctrl: got %b want 100", {in_ready, alu_start, out_valid}); end
        n_cmp++; if ({alu_a, alu_b, alu_opcode, out_result, out_opcode, out_err} !== '0) begin
            n_bad++; $display("FAIL rmid_regs: got %h %h %b %h %b %b want 0", alu_a, alu_b, alu_opcode, out_result, out_opcode, out_err); end
        tick(); tick(); rst = 1'b0;
        div_val = 32'h5555_AAAA; div_drive = 1'b1; alu_done = 1'b1;
        tick(); alu_done = 1'b0; div_drive = 1'b0;
        seen = 0;
        repeat (12) begin if (out_valid === 1'b1 || alu_start === 1'b1) seen++; tick(); end
        n_cmp++; if (seen != 0) begin n_bad++; $display("FAIL rmid_stale: got %0d want 0", seen); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rmid_in_ready: got %b want 1", in_ready); end
    endtask

`ifdef FXP_SEQ_TIMEOUT_EN
    task automatic test_timeout();
        int w;
        int early;
        in_valid = 1'b1; in_a = 32'h9; in_b = 32'h0; in_opcode = 2'b10;
        tick(); in_valid = 1'b0;
        w = 0;
        while (alu_start !== 1'b1 && w < 10) begin tick(); w++; end
        n_cmp++; if (alu_start !== 1'b1) begin n_bad++; $display("FAIL tmo_start: got %b want 1", alu_start); end
        early = 0;
        repeat (64) begin tick(); if (out_valid === 1'b1) early++; end
        n_cmp++; if (early != 0) begin n_bad++; $display("FAIL tmo_early: got %0d want 0", early); end
        tick();
        n_cmp++; if ({out_valid, out_err, out_result} !== {1'b1, 1'b1, 32'h0}) begin
            n_bad++; $display("FAIL tmo_result: got v=%b err=%b %h want 1 1 0", out_valid, out_err, out_result); end
        div_val = 32'h1234; div_drive = 1'b1; alu_done = 1'b1;
        tick(); alu_done = 1'b0; div_drive = 1'b0;
        n_cmp++; if ({out_err, out_result} !== {1'b1, 32'h0}) begin n_bad++; $display("FAIL tmo_late_done: got err=%b %h want 1 0", out_err, out_result); end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        repeat (3) tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL tmo_no_extra: got %b want 0", out_valid); end
    endtask
`endif

    initial begin
        in_valid = 1'b0; in_a = '0; in_b = '0; in_opcode = 2'b00;
        alu_done = 1'b0; out_ready = 1'b0; div_val = '0; div_drive = 1'b0;
        test_reset();
        test_add();
        test_back_to_back();
        test_div();
        test_reserved();
        test_reset_mid();
`ifdef FXP_SEQ_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
`default_nettype wire
